// File: rtl/apb_pkg.sv
// apb_pkg: APB constants, FSM state encoding and decode helper shared by the bridge, responder and bench.
`default_nettype none

package apb_pkg;

  localparam int          APB_DATA_W     = 32;
  localparam int          APB_ADDR_W     = 32;
  localparam logic [31:0] APB_ID_DEFAULT = 32'hA9B0_0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_t;

  // Error when misaligned, beyond the bank, or writing the read-only ID register.
  function automatic logic apb_decode_err(
    input logic [11:0] offset,
    input logic        write,
    input int          num_regs
  );
    logic [12:0] limit;
    limit = 13'(4 * num_regs);
    return (offset[1:0] != 2'b00) ||
           ({1'b0, offset} >= limit) ||
           (write && (offset < 12'd4));
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: NUM_REGS x 32-bit storage with a constant ID register at index 0. Rev 1.0
`default_nettype none

module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = APB_ID_DEFAULT,
  parameter int          IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [APB_DATA_W-1:0] wdata,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (idx != '0)) begin
      regs[idx] <= wdata;
    end
  end

  assign rdata = (idx == '0) ? ID_VALUE : regs[idx];

endmodule

`default_nettype wire

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB responder over a register bank with programmable wait states and error response. Rev 1.0
`default_nettype none

module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = APB_ID_DEFAULT
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  apb_state_t  state;
  logic [3:0]  wait_cnt;
  logic [11:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;

  logic [11:0]      dec_addr;
  logic             dec_write;
  logic             dec_err;
  logic [IDX_W-1:0] dec_idx;
  logic [31:0]      bank_rdata;
  logic [31:0]      done_rdata;
  logic             bank_we;
  logic             unused_paddr_hi;

  assign unused_paddr_hi = ^Paddr[31:12];

  // In IDLE the live bus is decoded so a zero-wait transfer can complete off the SETUP edge.
  assign dec_addr   = (state == ST_IDLE) ? Paddr[11:0] : addr_q;
  assign dec_write  = (state == ST_IDLE) ? Pwrite : write_q;
  assign dec_idx    = dec_addr[IDX_W+1:2];
  assign dec_err    = apb_decode_err(dec_addr, dec_write, NUM_REGS);
  assign done_rdata = (dec_write || dec_err) ? 32'h0 : bank_rdata;
  assign bank_we    = (state == ST_READY) && Psel && write_q && !Pslverr;

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk   (Hclk),
    .rst   (Hreset),
    .we    (bank_we),
    .idx   (dec_idx),
    .wdata (wdata_q),
    .rdata (bank_rdata)
  );

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      Prdata   <= '0;
      Pready   <= 1'b0;
      Pslverr  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Pready  <= 1'b0;
          Pslverr <= 1'b0;
          Prdata  <= '0;
          if (Psel && !Penable) begin
            addr_q   <= Paddr[11:0];
            write_q  <= Pwrite;
            wdata_q  <= Pwdata;
            wait_cnt <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state   <= ST_READY;
              Pready  <= 1'b1;
              Pslverr <= dec_err;
              Prdata  <= done_rdata;
            end else begin
              state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (!Psel) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (Penable) begin
            if (wait_cnt <= 4'd1) begin
              state    <= ST_READY;
              wait_cnt <= '0;
              Pready   <= 1'b1;
              Pslverr  <= dec_err;
              Prdata   <= done_rdata;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
        end

        ST_READY: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
          Pready   <= 1'b0;
          Pslverr  <= 1'b0;
          Prdata   <= '0;
        end

        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
          Pready   <= 1'b0;
          Pslverr  <= 1'b0;
          Prdata   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed bench for a one-wait and a zero-wait responder instance.
`default_nettype none

module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite, use_zw;
  logic [31:0] paddr, pwdata;

  logic        psel_a, psel_b;
  logic [31:0] prdata_a, prdata_b, prdata;
  logic        pready_a, pready_b, pready;
  logic        pslverr_a, pslverr_b, pslverr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign psel_a  = psel & ~use_zw;
  assign psel_b  = psel & use_zw;
  assign prdata  = use_zw ? prdata_b  : prdata_a;
  assign pready  = use_zw ? pready_b  : pready_a;
  assign pslverr = use_zw ? pslverr_b : pslverr_a;

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(1), .ID_VALUE(32'hA9B0_0001)) dut_a (
    .Hclk(clk), .Hreset(rst), .Psel(psel_a), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata_a), .Pready(pready_a), .Pslverr(pslverr_a)
  );

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(32'hA9B0_0001)) dut_b (
    .Hclk(clk), .Hreset(rst), .Psel(psel_b), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata_b), .Pready(pready_b), .Pslverr(pslverr_b)
  );

  // Starts SETUP immediately (caller sits just after a rising edge) and ends one cycle after READY.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output logic err, output int waits);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (pready) break;
      waits++;
      if (waits > 20) break;
    end
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL xfer_timeout addr=%h: Pready=%b required 1", addr, pready);
    end
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; use_zw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pready_a !== 1'b0)   begin errors++; $display("FAIL rst_pready_a: got %b required 0", pready_a); end
    checks++; if (pslverr_a !== 1'b0)  begin errors++; $display("FAIL rst_pslverr_a: got %b required 0", pslverr_a); end
    checks++; if (prdata_a !== 32'h0)  begin errors++; $display("FAIL rst_prdata_a: got %h required 0", prdata_a); end
    checks++; if (pready_b !== 1'b0)   begin errors++; $display("FAIL rst_pready_b: got %b required 0", pready_b); end
    checks++; if (pslverr_b !== 1'b0)  begin errors++; $display("FAIL rst_pslverr_b: got %b required 0", pslverr_b); end
    checks++; if (prdata_b !== 32'h0)  begin errors++; $display("FAIL rst_prdata_b: got %h required 0", prdata_b); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic err; int w;
    use_zw = 1'b0;
    xfer(1'b1, 32'h004, 32'hDEAD_BEEF, rd, err, w);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr4_slverr: got %b required 0", err); end
    checks++; if (w != 1)       begin errors++; $display("FAIL wr4_waits: got %0d required 1", w); end
    xfer(1'b0, 32'h004, 32'h0, rd, err, w);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd4_data: got %h required deadbeef", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd4_slverr: got %b required 0", err); end
    checks++; if (w != 1)       begin errors++; $display("FAIL rd4_waits: got %0d required 1", w); end
  endtask

  task automatic test_id;
    logic [31:0] rd; logic err; int w;
    xfer(1'b0, 32'h000, 32'h0, rd, err, w);
    checks++; if (rd !== 32'hA9B0_0001) begin errors++; $display("FAIL id_read: got %h required a9b00001", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL id_read_slverr: got %b required 0", err); end
    xfer(1'b1, 32'h000, 32'h0, rd, err, w);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL id_write_slverr: got %b required 1", err); end
    xfer(1'b0, 32'h000, 32'h0, rd, err, w);
    checks++; if (rd !== 32'hA9B0_0001) begin errors++; $display("FAIL id_reread: got %h required a9b00001", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic err; int w;
    xfer(1'b0, 32'h020, 32'h0, rd, err, w);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_slverr: got %b required 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oob_prdata: got %h required 0", rd); end
    xfer(1'b1, 32'h006, 32'h1111_1111, rd, err, w);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_slverr: got %b required 1", err); end
    xfer(1'b0, 32'h004, 32'h0, rd, err, w);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_reg1: got %h required deadbeef", rd); end
    xfer(1'b0, 32'h01C, 32'h0, rd, err, w);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL last_reg_slverr: got %b required 0", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL last_reg_data: got %h required 0", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic err; int w;
    use_zw = 1'b1;
    xfer(1'b1, 32'h008, 32'hA5A5_0008, rd, err, w);
    checks++; if (w != 0)       begin errors++; $display("FAIL b2b_wr8_waits: got %0d required 0", w); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_wr8_slverr: got %b required 0", err); end
    xfer(1'b1, 32'h00C, 32'h5A5A_000C, rd, err, w);
    checks++; if (w != 0)       begin errors++; $display("FAIL b2b_wrC_waits: got %0d required 0", w); end
    @(negedge clk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL b2b_pulse: Pready got %b required 0", pready); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h008, 32'h0, rd, err, w);
    checks++; if (rd !== 32'hA5A5_0008) begin errors++; $display("FAIL b2b_rd8: got %h required a5a50008", rd); end
    xfer(1'b0, 32'h00C, 32'h0, rd, err, w);
    checks++; if (rd !== 32'h5A5A_000C) begin errors++; $display("FAIL b2b_rdC: got %h required 5a5a000c", rd); end
    use_zw = 1'b0;
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic err; int w; logic seen;
    use_zw = 1'b0;
    xfer(1'b1, 32'h010, 32'hCAFE_0010, rd, err, w);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pready_a) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_pready: got %b required 0", seen); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h010, 32'h0, rd, err, w);
    checks++; if (rd !== 32'hCAFE_0010) begin errors++; $display("FAIL abort_reg4: got %h required cafe0010", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic err; int w;
    logic [31:0] addr;
    use_zw = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h014; pwdata = 32'h0000_0077;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    checks++; if (pready_a !== 1'b0)  begin errors++; $display("FAIL midrst_pready: got %b required 0", pready_a); end
    checks++; if (pslverr_a !== 1'b0) begin errors++; $display("FAIL midrst_pslverr: got %b required 0", pslverr_a); end
    @(posedge clk); #1;
    for (int i = 1; i < 8; i++) begin
      addr = 32'(4 * i);
      xfer(1'b0, addr, 32'h0, rd, err, w);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_reg%0d: got %h required 0", i, rd); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write_read;
    test_id;
    test_errors;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
